// File: rtl/snakes_pkg.sv
// Shared game-state encoding, score/level widths and the move-period rule
// used by the snake game controller.
package snakes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam int SCORE_W = 7;
  localparam int LEVEL_W = 3;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = '1;

  // Cycles between move ticks: each level shaves two cycles, floored at min_div.
  function automatic int calc_div(input int base_div, input int min_div, input int level);
    int d;
    d = base_div - 2 * level;
    return (d < min_div) ? min_div : d;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus rising-edge detector for a raw push button;
// emits a single registered press pulse per press.
module btn_sync_edge (
  input  logic clk,
  input  logic nRst_i,
  input  logic btn_i,
  output logic press_o
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       r_armed;
  logic       r_press;

  // r_armed stays low until the settled synchronizer has shown the button
  // released, so a button held across reset release never yields a press.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_s1   <= btn_i;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1] && !r_s2) begin
        r_armed <= 1'b1;
      end
      r_press <= r_s2 & ~r_s3 & r_armed;
    end
  end

  assign press_o = r_press;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game controller: game-state FSM, speed-scaled move tick generator,
// score/level bookkeeping and stopwatch control strobes.
module snake_game_ctrl
  import snakes_pkg::*;
#(
  parameter int BASE_DIV       = 20,
  parameter int MIN_DIV        = 4,
  parameter int APPLES_PER_LVL = 4
) (
  input  logic               clk,
  input  logic               nRst_i,
  input  logic               start_btn_i,
  input  logic               pause_btn_i,
  input  logic               collision_i,
  input  logic               apple_i,
  output logic [1:0]         state_o,
  output logic               tick_o,
  output logic               timer_clr_o,
  output logic               timer_en_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int CNT_W = $clog2(BASE_DIV + 1);

  logic w_start_p;
  logic w_pause_p;

  btn_sync_edge u_start_btn (
    .clk     (clk),
    .nRst_i  (nRst_i),
    .btn_i   (start_btn_i),
    .press_o (w_start_p)
  );

  btn_sync_edge u_pause_btn (
    .clk     (clk),
    .nRst_i  (nRst_i),
    .btn_i   (pause_btn_i),
    .press_o (w_pause_p)
  );

  game_state_e        r_state;
  game_state_e        w_state_nx;
  logic               r_tick;
  logic               r_clr;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_div;
  logic [SCORE_W-1:0] r_score;
  logic [LEVEL_W-1:0] r_level;

  // Collision outranks any pause press arriving in the same RUN cycle.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_p) w_state_nx = ST_RUN;
      ST_RUN: begin
        if (collision_i)    w_state_nx = ST_OVER;
        else if (w_pause_p) w_state_nx = ST_PAUSE;
      end
      ST_PAUSE: if (w_pause_p) w_state_nx = ST_RUN;
      ST_OVER:  if (w_start_p) w_state_nx = ST_RUN;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  logic               w_enter;
  logic               w_stay_run;
  logic               w_wrap;
  logic               w_apple_ok;
  logic [SCORE_W-1:0] w_score_inc;
  logic               w_lvl_up;
  logic [CNT_W-1:0]   w_div_nx;

  assign w_enter     = w_start_p && ((r_state == ST_IDLE) || (r_state == ST_OVER));
  assign w_stay_run  = (r_state == ST_RUN) && (w_state_nx == ST_RUN);
  assign w_wrap      = w_stay_run && (r_cnt == r_div - 1'b1);
  assign w_apple_ok  = (r_state == ST_RUN) && apple_i && !collision_i && (r_score != SCORE_MAX);
  assign w_score_inc = r_score + 1'b1;
  assign w_lvl_up    = ((int'(w_score_inc) % APPLES_PER_LVL) == 0) && (r_level != LEVEL_MAX);
  assign w_div_nx    = CNT_W'(calc_div(BASE_DIV, MIN_DIV, int'(r_level)));

  // The tick period is latched at each wrap, so a level change only
  // shortens the period that starts after the next wrap.
  always_ff @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      r_state <= ST_IDLE;
      r_tick  <= 1'b0;
      r_clr   <= 1'b0;
      r_cnt   <= '0;
      r_div   <= CNT_W'(BASE_DIV);
      r_score <= '0;
      r_level <= '0;
    end else begin
      r_state <= w_state_nx;
      r_clr   <= w_enter;
      r_tick  <= w_wrap;
      if (w_enter) begin
        r_cnt   <= '0;
        r_div   <= CNT_W'(BASE_DIV);
        r_score <= '0;
        r_level <= '0;
      end else begin
        if (w_wrap) begin
          r_cnt <= '0;
          r_div <= w_div_nx;
        end else if (w_stay_run) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_apple_ok) begin
          r_score <= w_score_inc;
          if (w_lvl_up) begin
            r_level <= r_level + 1'b1;
          end
        end
      end
    end
  end

  assign state_o     = r_state;
  assign tick_o      = r_tick;
  assign timer_clr_o = r_clr;
  assign timer_en_o  = (r_state == ST_RUN);
  assign score_o     = r_score;
  assign level_o     = r_level;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Self-checking bench for snake_game_ctrl: directed scenarios with literal
// expectations plus randomized play checked every cycle against a game model.
module tb_snake_game_ctrl;

  localparam int W = 15;

  logic       clk = 1'b0;
  logic       nRst_i = 1'b0;
  logic       start_btn_i = 1'b0;
  logic       pause_btn_i = 1'b0;
  logic       collision_i = 1'b0;
  logic       apple_i = 1'b0;
  logic [1:0] state_o;
  logic       tick_o;
  logic       timer_clr_o;
  logic       timer_en_o;
  logic [6:0] score_o;
  logic [2:0] level_o;

  int n_checks = 0;
  int n_errors = 0;

  snake_game_ctrl dut (
    .clk         (clk),
    .nRst_i      (nRst_i),
    .start_btn_i (start_btn_i),
    .pause_btn_i (pause_btn_i),
    .collision_i (collision_i),
    .apple_i     (apple_i),
    .state_o     (state_o),
    .tick_o      (tick_o),
    .timer_clr_o (timer_clr_o),
    .timer_en_o  (timer_en_o),
    .score_o     (score_o),
    .level_o     (level_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- game model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit hs[$];
  bit hp[$];
  int m_state, m_score, m_level, m_cycles, m_period, m_nx;
  bit m_ps, m_pp, m_tick, m_enter;

  function automatic int period_for(input int lvl);
    int d;
    d = 20 - 2 * lvl;
    return (d < 4) ? 4 : d;
  endfunction

  function automatic logic [W-1:0] pack(input int st, input bit tk, input bit clr,
                                        input bit en, input int sc, input int lv);
    return {2'(st), tk, clr, en, 7'(sc), 3'(lv)};
  endfunction

  // A press is a 0->1 step between two post-reset samples of the raw button;
  // the game reacts to it three edges after the high sample was taken.
  always @(posedge clk or negedge nRst_i) begin
    if (!nRst_i) begin
      hs.delete();
      hp.delete();
      m_state = 0; m_score = 0; m_level = 0; m_cycles = 0; m_period = 20;
      exp_q.delete();
      exp_q.push_back(pack(0, 0, 0, 0, 0, 0));
    end else begin
      hs.push_back(start_btn_i);
      hp.push_back(pause_btn_i);
      if (hs.size() > 5) void'(hs.pop_front());
      if (hp.size() > 5) void'(hp.pop_front());
      m_ps = (hs.size() == 5) && hs[1] && !hs[0];
      m_pp = (hp.size() == 5) && hp[1] && !hp[0];
      m_nx = m_state;
      m_enter = 0;
      case (m_state)
        0: if (m_ps) begin m_nx = 1; m_enter = 1; end
        1: if (collision_i) m_nx = 3; else if (m_pp) m_nx = 2;
        2: if (m_pp) m_nx = 1;
        3: if (m_ps) begin m_nx = 1; m_enter = 1; end
        default: m_nx = 0;
      endcase
      m_tick = 0;
      if (m_enter) begin
        m_score = 0; m_level = 0; m_cycles = 0; m_period = 20;
      end else begin
        if (m_state == 1 && m_nx == 1) begin
          m_cycles++;
          if (m_cycles == m_period) begin
            m_tick = 1;
            m_cycles = 0;
            m_period = period_for(m_level);
          end
        end
        if (m_state == 1 && apple_i && !collision_i && m_score < 127) begin
          m_score++;
          if (m_score % 4 == 0 && m_level < 7) m_level++;
        end
      end
      m_state = m_nx;
      exp_q.push_back(pack(m_state, m_tick, m_enter, (m_state == 1), m_score, m_level));
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_o, tick_o, timer_clr_o, timer_en_o, score_o, level_o};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL model_cmp t=%0t got st=%0d tk=%0b clr=%0b en=%0b sc=%0d lv=%0d want st=%0d tk=%0b clr=%0b en=%0b sc=%0d lv=%0d",
                 $time, a[14:13], a[12], a[11], a[10], a[9:3], a[2:0],
                 e[14:13], e[12], e[11], e[10], e[9:3], e[2:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_o && n < 200);
    if (!tick_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL tick_timeout: got no tick in %0d cycles want tick", n);
    end
  endtask

  task automatic press_start();
    start_btn_i = 1'b1;
    repeat (4) @(negedge clk);
    start_btn_i = 1'b0;
  endtask

  task automatic apples(input int count, input int gap);
    for (int i = 0; i < count; i++) begin
      apple_i = 1'b1;
      @(negedge clk);
      apple_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_random(input int cycles, input int coll_inv, input int apple_inv,
                            input int rst_inv);
    for (int i = 0; i < cycles; i++) begin
      if (rst_inv > 0 && $urandom_range(0, rst_inv - 1) == 0) begin
        @(posedge clk);
        #2 nRst_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        nRst_i = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) start_btn_i = ~start_btn_i;
      if ($urandom_range(0, 11) == 0) pause_btn_i = ~pause_btn_i;
      collision_i = ($urandom_range(0, coll_inv - 1) == 0);
      apple_i     = ($urandom_range(0, apple_inv - 1) == 0);
      @(negedge clk);
    end
    collision_i = 1'b0;
    apple_i = 1'b0;
    start_btn_i = 1'b0;
    pause_btn_i = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int ticks;
    start_btn_i = 1'b1;
    nRst_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state_o, 0);
    check("rst_score", score_o, 0);
    check("rst_tick", tick_o, 0);
    nRst_i = 1'b1;
    repeat (10) @(negedge clk);
    check("held_btn_idle", state_o, 0);
    start_btn_i = 1'b0;
    repeat (4) @(negedge clk);

    start_btn_i = 1'b1;
    repeat (3) @(negedge clk);
    check("start_edge3_idle", state_o, 0);
    @(negedge clk);
    check("start_edge4_run", state_o, 1);
    check("start_clr", timer_clr_o, 1);
    check("start_en", timer_en_o, 1);
    @(negedge clk);
    check("clr_one_cycle", timer_clr_o, 0);
    start_btn_i = 1'b0;
    wait_tick(n);
    check("first_tick_gap", n, 19);
    wait_tick(n);
    check("tick_spacing_20", n, 20);

    repeat (4) @(negedge clk);
    pause_btn_i = 1'b1;
    repeat (4) @(negedge clk);
    check("pause_state", state_o, 2);
    check("pause_en", timer_en_o, 0);
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) pause_btn_i = 1'b0;
      @(negedge clk);
      ticks += int'(tick_o);
    end
    check("pause_no_tick", ticks, 0);
    check("pause_hold", state_o, 2);
    pause_btn_i = 1'b1;
    repeat (4) @(negedge clk);
    check("resume_run", state_o, 1);
    check("resume_no_clr", timer_clr_o, 0);
    pause_btn_i = 1'b0;
    wait_tick(n);
    check("resume_tick_13", n, 13);

    apples(8, 2);
    check("score_8", score_o, 8);
    check("level_2", level_o, 2);
    wait_tick(n);
    wait_tick(n);
    check("tick_spacing_16", n, 16);

    collision_i = 1'b1;
    @(negedge clk);
    collision_i = 1'b0;
    check("coll_over", state_o, 3);
    check("over_score_hold", score_o, 8);
    press_start();
    check("restart_run", state_o, 1);
    check("restart_clr", timer_clr_o, 1);
    check("restart_score0", score_o, 0);
    apples(3, 2);
    collision_i = 1'b1;
    apple_i = 1'b1;
    @(negedge clk);
    collision_i = 1'b0;
    apple_i = 1'b0;
    check("coll_apple_over", state_o, 3);
    check("coll_apple_score3", score_o, 3);
    pause_btn_i = 1'b1;
    repeat (6) @(negedge clk);
    pause_btn_i = 1'b0;
    check("pause_in_over_ignored", state_o, 3);
    repeat (3) @(negedge clk);
    press_start();
    check("over_restart_run", state_o, 1);
    check("over_restart_clr", timer_clr_o, 1);
    check("over_restart_score0", score_o, 0);

    apple_i = 1'b1;
    repeat (130) @(negedge clk);
    apple_i = 1'b0;
    check("score_sat_127", score_o, 127);
    check("level_sat_7", level_o, 7);
    wait_tick(n);
    wait_tick(n);
    check("tick_spacing_l7", n, 6);

    collision_i = 1'b1;
    @(negedge clk);
    collision_i = 1'b0;
    repeat (3) @(negedge clk);
    press_start();
    apples(5, 1);
    check("pre_rst_score5", score_o, 5);
    @(posedge clk);
    #2 nRst_i = 1'b0;
    #1;
    check("midrst_state", state_o, 0);
    check("midrst_tick", tick_o, 0);
    check("midrst_clr", timer_clr_o, 0);
    check("midrst_en", timer_en_o, 0);
    check("midrst_score", score_o, 0);
    check("midrst_level", level_o, 0);
    repeat (2) @(negedge clk);
    nRst_i = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", state_o, 0);
    check("post_rst_no_clr", timer_clr_o, 0);

    run_random(2000, 3000, 2, 0);
    run_random(3000, 80, 6, 700);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by t=%0t want finish", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snake_game_ctrl.md
SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

Interface
REQ-001 Parameter: BASE_DIV, 20, clock cycles between move ticks at speed level 0.
REQ-002 Parameter: MIN_DIV, 4, floor on cycles between move ticks.
REQ-003 Parameter: APPLES_PER_LVL, 4, apples eaten per speed-level increment.
REQ-004 Port: clk  input  1  system clock; all flops on rising edge.
REQ-005 Port: nRst_i  input  1  asynchronous, active-low reset.
REQ-006 Port: start_btn_i  input  1  raw start/restart button, asynchronous to clk.
REQ-007 Port: pause_btn_i  input  1  raw pause/resume button, asynchronous to clk.
REQ-008 Port: collision_i  input  1  one-cycle pulse from snake datapath: head hit wall/body.
REQ-009 Port: apple_i  input  1  one-cycle pulse from snake datapath: apple eaten.
REQ-010 Port: state_o  output  2  game state (IDLE/RUN/PAUSE/OVER).
REQ-011 Port: tick_o  output  1  one-cycle move strobe to snake datapath.
REQ-012 Port: timer_clr_o  output  1  one-cycle clear strobe to play-time stopwatch.
REQ-013 Port: timer_en_o  output  1  stopwatch count enable, high only in RUN.
REQ-014 Port: score_o  output  7  apples eaten this game.
REQ-015 Port: level_o  output  3  current speed level.

Function
REQ-016 Each button SHALL pass a 2-flop synchronizer then a rising-edge detector, giving one press pulse per press regardless of hold length.
REQ-017 Press pulse SHALL assert on the 3rd rising edge at which the raw button is high; state_o SHALL update on the following edge (4 edges total).
REQ-018 States: IDLE->RUN on start press; RUN->PAUSE on pause press; PAUSE->RUN on pause press; RUN->OVER on collision_i; OVER->RUN on start press; all others hold.
REQ-019 Start press in RUN or PAUSE SHALL be ignored; pause press in IDLE or OVER SHALL be ignored.
REQ-020 Entry into RUN from IDLE or OVER SHALL pulse timer_clr_o for exactly one cycle and zero score_o, level_o and the tick counter in that same cycle.
REQ-021 Tick counter SHALL run only in RUN; tick_o pulses one cycle when count reaches DIV-1, counter then wraps to 0; PAUSE freezes count; first tick after IDLE/OVER exit occurs DIV cycles after the state change.
REQ-022 DIV = max(BASE_DIV - 2*level_o, MIN_DIV); a level change takes effect from the next counter wrap.
REQ-023 apple_i in RUN SHALL increment score_o, saturating at 127; apple_i outside RUN ignored.
REQ-024 level_o SHALL increment when the new score is a nonzero multiple of APPLES_PER_LVL, saturating at 7.
REQ-025 collision_i and apple_i in the same RUN cycle: collision wins, score unchanged, state->OVER.
REQ-026 collision_i and pause press in the same cycle: state->OVER.
REQ-027 collision_i outside RUN ignored; score_o and level_o hold through PAUSE and OVER.
REQ-028 tick_o SHALL never assert outside RUN; timer_en_o = (state_o == RUN).

Reset
REQ-029 nRst_i low SHALL immediately force state_o=IDLE, tick_o=0, timer_clr_o=0, timer_en_o=0, score_o=0, level_o=0, tick counter and synchronizer/edge flops to 0, including mid-game.
REQ-030 A button held through reset release SHALL NOT generate a press pulse until released and pressed again.

Structure
REQ-031 State enum (IDLE=0, RUN=1, PAUSE=2, OVER=3) and score/level widths SHALL live in shared package snakes_pkg.
REQ-032 Synchronizer plus edge detector SHALL be sub-module btn_sync_edge, instantiated once per button.

Verification
REQ-033 Reset with start_btn_i held high -> state_o=IDLE, score_o=0, tick_o=0; release reset, keep button high 10 cycles -> still IDLE.
REQ-034 Start press in IDLE -> RUN 4 edges later, one timer_clr_o pulse; tick_o every 20 cycles thereafter.
REQ-035 Pause press in RUN at tick count 7 -> PAUSE, no ticks for 50 cycles; resume -> next tick 13 cycles after RUN re-entry.
REQ-036 Eight apple_i pulses in RUN -> score_o=8, level_o=2, tick spacing 16 after next wrap.
REQ-037 collision_i and apple_i same cycle at score 3 -> OVER, score_o=3; start press -> RUN, score_o=0, timer_clr_o pulse.
REQ-038 nRst_i low mid-RUN at score 5 -> all outputs at reset values within same cycle, no timer_clr_o pulse.
